addsub_serial_nbits: RTL

Multi-cycle, digit-serial add/subtract unit for the calculator datapath. It is the parametrised, clocked successor of the combinational n-bit subtractor. It processes `digit` bits per clock, LSB first, behind a start/busy/done handshake. It produces a (width+1)-bit result plus zero and signed-overflow flags, and trades latency for a small adder so that wide operands fit the calculator core.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/full_add_digit.sv | 29 ++
 rtl/addsub_serial_nbits.sv | 117 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit:
// mode encoding, FSM states and counter sizing.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter only has to reach N-1, but it never shrinks below one bit.
    function automatic int count_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_add_digit.sv
// Combinational digit-wide ripple adder.
// It also exposes the carry into its top bit so the caller can derive signed overflow.
module full_add_digit #(
    parameter int digit = 2
) (
    input  logic [digit-1:0] x,
    input  logic [digit-1:0] y,
    input  logic             cin,
    output logic [digit-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [digit:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < digit; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout     = c[digit];
    assign c_msb_in = c[digit-1];

endmodule

// File: rtl/addsub_serial_nbits.sv
// Digit-serial add/subtract, LSB first, with a start/busy/done handshake.
// width must be >= 2, and digit must divide width evenly.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start_i; the last result is held on s_o
// ST_RUN  | one operand digit is added per cycle, N cycles in total
// ST_DONE | single cycle with done_o high; start_i may chain a new op
module addsub_serial_nbits
    import addsub_pkg::*;
#(
    parameter int width = 8,
    parameter int digit = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width:0]   s_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int N  = width / digit;
    localparam int CW = count_width(width, digit);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state, state_nxt;
    logic [width-1:0] opa, opb, sreg, sreg_nxt;
    logic             carry, mode_r;
    logic [CW-1:0]    count;
    logic [digit-1:0] dsum;
    logic             dcout, dcmsb;
    logic             last;
    int               base;

    assign base = int'(count) * digit;
    assign last = (count == LAST);

    full_add_digit #(.digit(digit)) u_fad (
        .x        (opa[base +: digit]),
        .y        (opb[base +: digit]),
        .cin      (carry),
        .s        (dsum),
        .cout     (dcout),
        .c_msb_in (dcmsb)
    );

    // New digits enter at the top, so after N shifts digit 0 sits at bit 0.
    if (digit == width) begin : g_single
        assign sreg_nxt = dsum;
    end else begin : g_shift
        assign sreg_nxt = {dsum, sreg[width-1:digit]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_RUN;
            ST_RUN:  if (last)    state_nxt = ST_DONE;
            ST_DONE: state_nxt = start_i ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opa    <= '0;
            opb    <= '0;
            sreg   <= '0;
            carry  <= 1'b0;
            mode_r <= 1'b0;
            count  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            s_o    <= '0;
            zero_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            busy_o <= (state_nxt == ST_RUN);
            done_o <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        opa    <= a_i;
                        opb    <= b_i ^ {width{mode_i}};
                        carry  <= mode_i;
                        mode_r <= mode_i;
                        count  <= '0;
                    end
                end
                ST_RUN: begin
                    sreg  <= sreg_nxt;
                    carry <= dcout;
                    count <= count + 1'b1;
                    if (last) begin
                        // On subtract the top bit is a borrow, i.e. the inverted carry.
                        s_o    <= {(mode_r == MODE_SUB) ? ~dcout : dcout, sreg_nxt};
                        zero_o <= (sreg_nxt == '0);
                        ovf_o  <= dcmsb ^ dcout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
